// File: rtl/boot_loader_pkg.sv
// boot_loader_pkg: shared states, header/word byte counts and lane index types for the imem boot loader
package boot_loader_pkg;
  typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, DONE, ERR} state_t;
  localparam int HdrBytes = 2;
  localparam int BytesPerWord = 4;
  typedef logic [$clog2(BytesPerWord)-1:0] lane_t;
  typedef logic [$clog2(HdrBytes)-1:0] hdr_idx_t;
endpackage

// File: rtl/word_packer.sv
// word_packer: assembles four bytes little-endian into a 32-bit word, exposing the completed word in the cycle its last byte arrives
module word_packer import boot_loader_pkg::*; (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        full_o
);
  logic [23:0] r_sr;
  lane_t       r_lane;
  assign word_o = {byte_i, r_sr};
  assign full_o = shift_i && r_lane == lane_t'(BytesPerWord - 1);
  // shift older bytes down so the first byte of a word ends up in bits [7:0]
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_sr   <= '0;
      r_lane <= '0;
    end else if (clear_i) begin
      r_sr   <= '0;
      r_lane <= '0;
    end else if (shift_i) begin
      r_sr   <= {byte_i, r_sr[23:8]};
      r_lane <= lane_t'(r_lane + 1'b1);
    end
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams a counted byte image into imem through the core load port while holding the core in reset
module imem_boot_loader import boot_loader_pkg::*; #(
  parameter int AddressWidth  = 10,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 1000000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    byte_valid_i,
  input  logic [7:0]              byte_data_i,
  output logic                    byte_ready_o,
  output logic                    imem_ld_o,
  output logic [AddressWidth-1:0] imem_ld_addr_o,
  output logic [DataWidth-1:0]    imem_ld_data_o,
  output logic                    core_rst_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o
);
  state_t                  r_state;
  hdr_idx_t                r_hdr_cnt;
  logic [15:0]             r_n;
  logic [AddressWidth-1:0] r_idx;
  logic [31:0]             r_idle;
  logic                    r_ld, r_core_rst, r_busy, r_done, r_err;
  logic [AddressWidth-1:0] r_addr;
  logic [DataWidth-1:0]    r_data;
  logic                    w_ready, w_xfer, w_clear, w_full, w_tmo, w_last;
  logic [15:0]             w_n;
  logic [31:0]             w_word;
  assign w_ready = r_state == HDR || r_state == DATA;
  assign w_xfer  = w_ready && byte_valid_i;
  assign w_clear = start_i && (r_state == IDLE || r_state == DONE || r_state == ERR);
  assign w_n     = {byte_data_i, r_n[7:0]};
  assign w_tmo   = TimeoutCycles != 0 && r_idle == 32'(TimeoutCycles - 1);
  assign w_last  = 32'(r_idx) + 32'd1 == 32'(r_n);
  assign byte_ready_o   = w_ready;
  assign imem_ld_o      = r_ld;
  assign imem_ld_addr_o = r_addr;
  assign imem_ld_data_o = r_data;
  assign core_rst_o     = r_core_rst;
  assign busy_o         = r_busy;
  assign done_o         = r_done;
  assign err_o          = r_err;
  word_packer u_packer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (w_clear),
    .shift_i (w_xfer && r_state == DATA),
    .byte_i  (byte_data_i),
    .word_o  (w_word),
    .full_o  (w_full)
  );
  // load sequencer: header parse, word writes, timeout and completion status
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_state    <= IDLE;
      r_hdr_cnt  <= '0;
      r_n        <= '0;
      r_idx      <= '0;
      r_idle     <= '0;
      r_ld       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_core_rst <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_idle <= (w_ready && !w_xfer) ? r_idle + 32'd1 : '0;
      case (r_state)
        IDLE, DONE, ERR:
          if (start_i) begin
            r_state    <= HDR;
            r_hdr_cnt  <= '0;
            r_idx      <= '0;
            r_core_rst <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
          end
        HDR:
          if (w_xfer && r_hdr_cnt != hdr_idx_t'(HdrBytes - 1)) begin
            r_n[7:0]  <= byte_data_i;
            r_hdr_cnt <= hdr_idx_t'(r_hdr_cnt + 1'b1);
          end else if (w_xfer) begin
            r_n[15:8] <= byte_data_i;
            if (w_n == 16'd0) begin
              r_state    <= DONE;
              r_core_rst <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
            end else if ({16'd0, w_n} > (32'd1 << AddressWidth)) begin
              r_state <= ERR;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
            end else
              r_state <= DATA;
          end else if (w_tmo) begin
            r_state <= ERR;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end
        DATA:
          if (w_full) begin
            r_state <= WRITE;
            r_ld    <= 1'b1;
            r_addr  <= r_idx;
            r_data  <= DataWidth'(w_word);
          end else if (!w_xfer && w_tmo) begin
            r_state <= ERR;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end
        WRITE: begin
          r_ld <= 1'b0;
          if (w_last) begin
            r_state    <= DONE;
            r_core_rst <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
          end else begin
            r_state <= DATA;
            r_idx   <= r_idx + AddressWidth'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule
